prog_clk_div: RTL and testbench
===============================

# prog_clk_div

Runtime-programmable clock divider, the parametrised successor of the fixed-ratio divider. It produces a registered divided clock with a programmable period and high time, plus a one-cycle period-start strobe. Its configuration is loaded through a valid/ready handshake and takes effect only at period boundaries, so the output is glitch-free across reprogramming. It sits between the system clock and slow peripherals such as baud generators, PWM and LED drivers, and serves either as a clock-enable source or as a divided clock.

## Interface
- W, 16, width of the divisor and high-time fields; W >= 2
- DEFAULT_DIV, 5, period in clk_i cycles after reset; 2 <= DEFAULT_DIV <= 2^W-1
- DEFAULT_HIGH, 2, high time in cycles after reset; 1 <= DEFAULT_HIGH <= DEFAULT_DIV-1

- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- en_i  in  1  run request; level-sensitive
- cfg_valid_i  in  1  configuration offered
- cfg_ready_o  out  1  configuration slot free (= no pending configuration)
- cfg_div_i  in  W  requested period in cycles
- cfg_high_i  in  W  requested high time in cycles
- cfg_err_o  out  1  one-cycle pulse: accepted configuration was invalid and discarded
- clk_o  out  1  divided clock, registered
- tick_o  out  1  one-cycle strobe coinciding with the first high cycle of every period
- running_o  out  1  divider in RUN or STOPPING

## Operation
- Registers:
  - active div_q / high_q
  - shadow pend_div_q / pend_high_q with pend_q flag
  - counter cnt_q (W bits, 0..div_q-1)
  - state_q
- Handshake:
  - transfer on the edge where cfg_valid_i && cfg_ready_o.
  - cfg_ready_o = !pend_q; it is combinational from a register.
- Validation at transfer: valid iff cfg_div_i >= 2 and 1 <= cfg_high_i <= cfg_div_i-1.
  - Invalid: cfg_err_o=1 for the next cycle, pend_q unchanged, active values unchanged.
  - The transfer still completes.
- Apply rule:
  - pending values move to active (and pend_q clears) on a wrap edge, a stop edge, or any edge while IDLE.
  - The decision uses pend_q as it was before the edge. A configuration accepted on a wrap edge therefore applies at the following boundary.
- States:
  - IDLE: clk_o=0, tick_o=0, cnt_q=0. en_i=1 → RUN, with cnt_q<=0, clk_o<=1, tick_o<=1.
  - RUN: cnt_q increments and wraps to 0 after div_q-1. clk_o <= (cnt_next < high_q). tick_o <= (cnt_next == 0). en_i=0 → STOPPING.
  - STOPPING: counts as in RUN. At the edge where cnt_q == div_q-1: → IDLE, cnt_q<=0, clk_o<=0, tick_o<=0. en_i=1 before that edge → RUN with no disturbance to the waveform.
- Arithmetic: cnt_next = (cnt_q == div_q-1) ? 0 : cnt_q+1. All comparisons are unsigned and W bits wide.

## Timing
- Start latency: clk_o and tick_o rise one cycle after the first edge that samples en_i=1 in IDLE.
- Every period is exactly div_q cycles, and clk_o is high for exactly high_q of them. Odd and even divisors are treated identically.
- A stop always completes the current period. running_o falls on the same edge that clk_o is forced to 0.
- Reset values:
  - clk_o=0, tick_o=0, cfg_err_o=0, running_o=0.
  - cfg_ready_o=1.
  - state IDLE, cnt_q=0, div_q=DEFAULT_DIV, high_q=DEFAULT_HIGH, pend_q=0.
- Reset mid-operation: all outputs go to their reset values immediately and asynchronously. Any pending configuration is lost.
- Simultaneous events: when a transfer coincides with a stop edge, the new configuration becomes pending and is applied on the next IDLE edge.
- Elaboration: parameter ranges are checked at elaboration; a violation is a fatal error.

## Structure
- Shared package prog_clk_div_pkg holds:
  - the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2
  - the validity-check function
- One sub-module is natural: div_cfg_shadow. It contains the handshake, validation, cfg_err_o, and the pending registers. It outputs pend_q, pend_div and pend_high, and takes an apply strobe.
- The counter, FSM and output registers live in the top module.

## Test plan
- Defaults, en_i=1 from reset release:
  - clk_o high 2, low 3, repeating; tick_o every 5 cycles
  - first high cycle exactly 1 cycle after en_i is sampled
- Mid-run reconfiguration: cfg div=4, high=2 at cnt_q=1:
  - cfg_ready_o stays 0 until the wrap
  - the current 5-cycle period completes, then 4-cycle 2/2 periods follow
- Invalid configurations (div=1; high=0; high=div=6):
  - each gives a cfg_err_o pulse, cfg_ready_o stays 1, and the waveform is unchanged
- Stop and resume:
  - en_i low at cnt_q=1 with div=5: running_o and clk_o low at the wrap edge
  - a separate run with en_i re-raised at cnt_q=3: the period train is unbroken
- Asynchronous reset asserted during the high phase:
  - clk_o, tick_o and running_o are 0 before the next edge
  - after release the divider restarts with defaults 5/2
- Extremes with W=4:
  - div=15, high=14: 14 high, 1 low
  - div=2, high=1: clk_o toggles every cycle and tick_o is high every other cycle

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state
// encodings and the configuration validity rule used when a new
// divisor/high-time pair is accepted.
package prog_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // A period needs at least two cycles and must contain both a high and a low phase.
  // Callers zero-extend their W-bit fields to 32 bits, so all comparisons are unsigned.
  function automatic logic cfg_is_valid(input logic [31:0] div, input logic [31:0] high);
    return (div >= 32'd2) && (high >= 32'd1) && (high <= div - 32'd1);
  endfunction

endpackage

// File: rtl/prog_clk_div_cfg_shadow.sv
// Configuration shadow for prog_clk_div: valid/ready intake, validation,
// one-cycle error pulse and the pending divisor/high-time registers.
// The slot frees up only when the top module strobes apply_i.
module div_cfg_shadow
  import prog_clk_div_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_valid_i,
  input  logic [W-1:0] cfg_div_i,
  input  logic [W-1:0] cfg_high_i,
  input  logic         apply_i,
  output logic         cfg_ready_o,
  output logic         cfg_err_o,
  output logic         pend_o,
  output logic [W-1:0] pend_div_o,
  output logic [W-1:0] pend_high_o
);

  logic         pend_d, pend_q;
  logic [W-1:0] pend_div_d, pend_div_q;
  logic [W-1:0] pend_high_d, pend_high_q;
  logic         err_d, err_q;
  logic         xfer;
  logic         ok;

  assign cfg_ready_o = !pend_q;
  assign xfer        = cfg_valid_i && !pend_q;
  assign ok          = cfg_is_valid(32'(cfg_div_i), 32'(cfg_high_i));

  // Capture a valid offer into the shadow slot; flag and drop an invalid one.
  // apply_i is only raised while pend_q is set, so it never races a transfer.
  always_comb begin
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    err_d       = 1'b0;
    if (apply_i) begin
      pend_d = 1'b0;
    end else if (xfer) begin
      if (ok) begin
        pend_d      = 1'b1;
        pend_div_d  = cfg_div_i;
        pend_high_d = cfg_high_i;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Shadow and error-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_high_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      err_q       <= err_d;
    end
  end

  assign cfg_err_o   = err_q;
  assign pend_o      = pend_q;
  assign pend_div_o  = pend_div_q;
  assign pend_high_o = pend_high_q;

endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider with registered clock output, period
// strobe and glitch-free reconfiguration applied only at period boundaries.
// Stopping always finishes the period in progress.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int W            = 16,
  parameter int DEFAULT_DIV  = 5,
  parameter int DEFAULT_HIGH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         cfg_valid_i,
  output logic         cfg_ready_o,
  input  logic [W-1:0] cfg_div_i,
  input  logic [W-1:0] cfg_high_i,
  output logic         cfg_err_o,
  output logic         clk_o,
  output logic         tick_o,
  output logic         running_o
);

  if (W < 2) begin : g_bad_w
    $fatal(1, "prog_clk_div: W must be at least 2");
  end
  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (1 << W) - 1) begin : g_bad_div
    $fatal(1, "prog_clk_div: DEFAULT_DIV out of range");
  end
  if (DEFAULT_HIGH < 1 || DEFAULT_HIGH > DEFAULT_DIV - 1) begin : g_bad_high
    $fatal(1, "prog_clk_div: DEFAULT_HIGH out of range");
  end

  state_e       state_d, state_q;
  logic [W-1:0] cnt_d, cnt_q;
  logic [W-1:0] div_d, div_q;
  logic [W-1:0] high_d, high_q;
  logic         clk_d, clk_q;
  logic         tick_d, tick_q;

  logic         pend;
  logic [W-1:0] pend_div, pend_high;
  logic         apply;
  logic         last;
  logic [W-1:0] cnt_nxt;

  div_cfg_shadow #(.W(W)) u_shadow (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_div_i   (cfg_div_i),
    .cfg_high_i  (cfg_high_i),
    .apply_i     (apply),
    .cfg_ready_o (cfg_ready_o),
    .cfg_err_o   (cfg_err_o),
    .pend_o      (pend),
    .pend_div_o  (pend_div),
    .pend_high_o (pend_high)
  );

  assign last    = (cnt_q == div_q - W'(1));
  assign cnt_nxt = last ? '0 : cnt_q + W'(1);
  // Boundaries: every wrap (which includes the stop edge) and any idle cycle.
  assign apply   = pend && ((state_q == ST_IDLE) || last);

  // Next-state, counter and output-register logic for the divider FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_nxt;
    clk_d   = (cnt_nxt < high_q);
    tick_d  = (cnt_nxt == '0);
    div_d   = apply ? pend_div  : div_q;
    high_d  = apply ? pend_high : high_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        clk_d  = en_i;
        tick_d = en_i;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_i) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (en_i) begin
          state_d = ST_RUN;
        end else if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          clk_d   = 1'b0;
          tick_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
      end
    endcase
  end

  // Divider state, active configuration and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= W'(DEFAULT_DIV);
      high_q  <= W'(DEFAULT_HIGH);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign running_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div (W=4, defaults 5/2). Each vector drives
// inputs for one rising edge; outputs are compared 1 ns after that edge as
// {clk_o, tick_o, running_o, cfg_ready_o, cfg_err_o}.
module tb_prog_clk_div;

  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         en_i = 1'b0;
  logic         cfg_valid_i = 1'b0;
  logic [W-1:0] cfg_div_i = '0;
  logic [W-1:0] cfg_high_i = '0;
  logic         cfg_ready_o, cfg_err_o, clk_o, tick_o, running_o;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic         en;
    logic         vld;
    logic [W-1:0] div;
    logic [W-1:0] high;
    logic [4:0]   exp;
  } vec_t;

  vec_t tbl_main[$];
  vec_t tbl_stop[$];

  prog_clk_div #(.W(W), .DEFAULT_DIV(5), .DEFAULT_HIGH(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_div_i   (cfg_div_i),
    .cfg_high_i  (cfg_high_i),
    .cfg_err_o   (cfg_err_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .running_o   (running_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic en, logic vld, int div, int high, logic [4:0] exp);
    vec_t v;
    v.en   = en;
    v.vld  = vld;
    v.div  = W'(div);
    v.high = W'(high);
    v.exp  = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {clk_o, tick_o, running_o, cfg_ready_o, cfg_err_o};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got clk/tick/run/rdy/err=%b, want %b", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    en_i        = v.en;
    cfg_valid_i = v.vld;
    cfg_div_i   = v.div;
    cfg_high_i  = v.high;
    @(posedge clk_i);
    #1;
    check(name, v.exp);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    en_i        = 1'b0;
    cfg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("reset", 5'b00010);
    rst_i = 1'b0;
  endtask

  // Runs n cycles from IDLE with en_i=1; expected waveform from div/high directly.
  task automatic run_periods(input int div, input int high, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      int m;
      m = k % div;
      step(mk(1'b1, 1'b0, 0, 0, {(m < high), (m == 0), 3'b110}),
           $sformatf("%s[%0d]", name, k));
    end
  endtask

  initial begin
    // defaults 5/2, then reconfigure to 4/2 at cnt_q=1, then three invalid offers
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_main.push_back(mk(1, 1, 4, 2, 5'b00100));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00100));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00100));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_main.push_back(mk(1, 1, 1, 1, 5'b00111));
    tbl_main.push_back(mk(1, 1, 4, 0, 5'b00111));
    tbl_main.push_back(mk(1, 1, 6, 6, 5'b11111));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_main.push_back(mk(1, 0, 0, 0, 5'b11110));

    // stop at cnt_q=1, idle, restart, then en_i re-raised at cnt_q=3 during stopping
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00010));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00010));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(0, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b11110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b10110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b00110));
    tbl_stop.push_back(mk(1, 0, 0, 0, 5'b11110));

    do_reset();
    foreach (tbl_main[i]) step(tbl_main[i], $sformatf("main[%0d]", i));

    do_reset();
    foreach (tbl_stop[i]) step(tbl_stop[i], $sformatf("stop[%0d]", i));

    // asynchronous reset during the high phase, then restart with defaults
    do_reset();
    step(mk(1, 0, 0, 0, 5'b11110), "pre_arst");
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_async", 5'b00010);
    @(posedge clk_i);
    #1;
    check("arst_hold", 5'b00010);
    rst_i = 1'b0;
    run_periods(5, 2, 10, "post_arst");

    // extreme 15/14 loaded while idle: pending for one edge, applied on the next
    do_reset();
    step(mk(0, 1, 15, 14, 5'b00000), "cfg15_xfer");
    step(mk(0, 0, 0, 0, 5'b00010), "cfg15_apply");
    run_periods(15, 14, 30, "div15");

    // extreme 2/1, then a transfer on the stop edge applies on the next idle edge
    do_reset();
    step(mk(0, 1, 2, 1, 5'b00000), "cfg2_xfer");
    step(mk(0, 0, 0, 0, 5'b00010), "cfg2_apply");
    run_periods(2, 1, 8, "div2");
    step(mk(0, 0, 0, 0, 5'b11110), "div2_stop0");
    step(mk(0, 0, 0, 0, 5'b00110), "div2_stop1");
    step(mk(0, 1, 3, 2, 5'b00000), "stop_edge_xfer");
    step(mk(0, 0, 0, 0, 5'b00010), "idle_apply");
    run_periods(3, 2, 6, "div3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, want completion within 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
